// File: rtl/capture_pkg.sv
// Shared types and defaults for the ADC capture transmit scheduler.
// Optional macro: CAPTURE_CHECKSUM_EN adds the checksum byte state.
package capture_pkg;

    localparam logic [7:0]  DefaultHeaderByte = 8'hA5;
    localparam int unsigned ChecksumWidth     = 8;
    localparam int unsigned FrameCountWidth   = 16;
    localparam int unsigned ByteCountWidth    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StHdr,
        StData,
`ifdef CAPTURE_CHECKSUM_EN
        StCsum,
`endif
        StWait
    } schedState_e;

endpackage

// File: rtl/tx_byte_handshake.sv
// Launches one UART byte: registered TxData/TxStart pulse, a guard cycle, then waits for TxBusy low.
// Shared by all byte sources of the capture transmit scheduler.
module tx_byte_handshake (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] LoadByte,
    input  logic       TxBusy,
    output logic [7:0] TxData,
    output logic       TxStart,
    output logic       Done
);

    logic [7:0] dataQ;
    logic       startQ;
    logic       waitingQ;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dataQ    <= 8'h00;
            startQ   <= 1'b0;
            waitingQ <= 1'b0;
        end else begin
            startQ <= Load;
            if (Load) begin
                dataQ    <= LoadByte;
                waitingQ <= 1'b1;
            end else if (Done) begin
                waitingQ <= 1'b0;
            end
        end
    end

    // The cycle carrying TxStart is the guard: the UART has not raised TxBusy yet.
    assign Done    = waitingQ && !startQ && !TxBusy;
    assign TxData  = dataQ;
    assign TxStart = startQ;

endmodule

// File: rtl/capture_tx_scheduler.sv
// Frames ADC FIFO bytes (header + BURST_LEN data) onto the UART, interleaving general bytes between frames.
// Optional macro: CAPTURE_CHECKSUM_EN appends a modulo-256 data checksum byte to each frame.
module capture_tx_scheduler
    import capture_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 256,
    parameter logic [7:0]  HEADER_BYTE = DefaultHeaderByte
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [7:0]                 GenData,
    input  logic                       GenDataWrite,
    output logic                       GenDataAck,
    input  logic [7:0]                 AdcData,
    input  logic                       AdcDataReady,
    output logic                       AdcReadEnable,
    output logic [7:0]                 TxData,
    output logic                       TxStart,
    input  logic                       TxBusy,
    output logic [FrameCountWidth-1:0] FrameCount
);

    localparam logic [ByteCountWidth-1:0] BurstLen = ByteCountWidth'(BURST_LEN);

    schedState_e                stateQ;
    schedState_e                retQ;
    logic [ByteCountWidth-1:0]  byteCountQ;
    logic [FrameCountWidth-1:0] frameCountQ;
    logic                       genAckQ;
    logic                       popQ;
`ifdef CAPTURE_CHECKSUM_EN
    logic [ChecksumWidth-1:0]   checksumQ;
`endif

    logic       txLoad;
    logic [7:0] txByte;
    logic       txDone;

    // Byte launched at the edge that leaves a sending state.
    always_comb begin
        txLoad = 1'b0;
        txByte = 8'h00;
        case (stateQ)
            StGen: begin
                txLoad = 1'b1;
                txByte = GenData;
            end
            StHdr: begin
                txLoad = 1'b1;
                txByte = HEADER_BYTE;
            end
            StData: begin
                txLoad = AdcDataReady;
                txByte = AdcData;
            end
`ifdef CAPTURE_CHECKSUM_EN
            StCsum: begin
                txLoad = 1'b1;
                txByte = checksumQ;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ      <= StIdle;
            retQ        <= StIdle;
            byteCountQ  <= '0;
            frameCountQ <= '0;
            genAckQ     <= 1'b0;
            popQ        <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
            checksumQ   <= '0;
`endif
        end else begin
            genAckQ <= 1'b0;
            popQ    <= 1'b0;
            case (stateQ)
                StIdle: begin
                    if (GenDataWrite) begin
                        stateQ <= StGen;
                    end else if (AdcDataReady) begin
                        stateQ <= StHdr;
                    end
                end
                StGen: begin
                    genAckQ <= 1'b1;
                    retQ    <= StIdle;
                    stateQ  <= StWait;
                end
                StHdr: begin
                    byteCountQ <= '0;
`ifdef CAPTURE_CHECKSUM_EN
                    checksumQ  <= '0;
`endif
                    retQ       <= StData;
                    stateQ     <= StWait;
                end
                StData: begin
                    if (AdcDataReady) begin
                        popQ       <= 1'b1;
                        byteCountQ <= byteCountQ + 1'b1;
`ifdef CAPTURE_CHECKSUM_EN
                        checksumQ  <= checksumQ + AdcData;
`endif
                        retQ       <= StData;
                        stateQ     <= StWait;
                    end
                end
`ifdef CAPTURE_CHECKSUM_EN
                StCsum: begin
                    // Return tag StCsum tells WAIT the frame is finished.
                    retQ   <= StCsum;
                    stateQ <= StWait;
                end
`endif
                StWait: begin
                    if (txDone) begin
                        case (retQ)
                            StData: begin
                                if (byteCountQ < BurstLen) begin
                                    stateQ <= StData;
                                end else begin
`ifdef CAPTURE_CHECKSUM_EN
                                    stateQ      <= StCsum;
`else
                                    stateQ      <= StIdle;
                                    frameCountQ <= frameCountQ + 1'b1;
`endif
                                end
                            end
`ifdef CAPTURE_CHECKSUM_EN
                            StCsum: begin
                                stateQ      <= StIdle;
                                frameCountQ <= frameCountQ + 1'b1;
                            end
`endif
                            default: stateQ <= StIdle;
                        endcase
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    tx_byte_handshake uTxHandshake (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (txLoad),
        .LoadByte (txByte),
        .TxBusy   (TxBusy),
        .TxData   (TxData),
        .TxStart  (TxStart),
        .Done     (txDone)
    );

    assign GenDataAck    = genAckQ;
    assign AdcReadEnable = popQ;
    assign FrameCount    = frameCountQ;

endmodule

// File: tb/tb_capture_tx_scheduler.sv
// Self-checking bench for capture_tx_scheduler: byte-stream reference model plus directed and random traffic.
// Honours CAPTURE_CHECKSUM_EN when the design is built with it.
module tb_capture_tx_scheduler;

    localparam int unsigned BurstLen = 4;
`ifdef CAPTURE_CHECKSUM_EN
    localparam int CsBytes = 1;
`else
    localparam int CsBytes = 0;
`endif

    logic        Clock;
    logic        Reset;
    logic [7:0]  GenData;
    logic        GenDataWrite;
    logic        GenDataAck;
    logic [7:0]  AdcData;
    logic        AdcDataReady;
    logic        AdcReadEnable;
    logic [7:0]  TxData;
    logic        TxStart;
    logic        TxBusy;
    logic [15:0] FrameCount;

    capture_tx_scheduler #(
        .BURST_LEN   (BurstLen),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .GenData       (GenData),
        .GenDataWrite  (GenDataWrite),
        .GenDataAck    (GenDataAck),
        .AdcData       (AdcData),
        .AdcDataReady  (AdcDataReady),
        .AdcReadEnable (AdcReadEnable),
        .TxData        (TxData),
        .TxStart       (TxStart),
        .TxBusy        (TxBusy),
        .FrameCount    (FrameCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Stimulus-side state
    logic [7:0] fifoQ[$];
    logic [7:0] pushed[$];
    logic [7:0] genQ[$];
    int         busyLen = 0;
    int         busyLeft = 0;
    bit         holdOff = 1'b0;

    // Reference model state
    logic [7:0] txLog[$];
    logic [7:0] expQ[$];
    int         cyc = 0;
    int         lastStart = -100;
    int         remaining = 0;
    bit         csumPending = 1'b0;
    logic [7:0] csumAcc = 8'h00;
    int         framesDone = 0;
    int         nextData = 0;
    bit         prevBusy = 1'b0;
    bit         prevReady = 1'b0;
    bit         gen1 = 1'b0;
    bit         gen2 = 1'b0;
    bit         rstPrev = 1'b0;
    int         popCnt = 0;
    int         ackCnt = 0;
    int         startCnt = 0;
    int         fcAtAck = -1;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-level model: every TxStart must carry the next byte the framing rules allow.
    always @(negedge Clock) begin
        logic [7:0] expB;
        bit         have;
        cyc++;
        if (rstPrev) begin
            check(!TxStart && !GenDataAck && !AdcReadEnable && TxData == 8'h00 && FrameCount == 16'h0,
                  "reset_outputs", {5'b0, TxStart, GenDataAck, AdcReadEnable, TxData, FrameCount}, 0);
        end
        if (TxStart) begin
            startCnt++;
            check((cyc - lastStart) >= 3 && !prevBusy, "start_spacing", cyc - lastStart, 3);
            check(FrameCount == 16'(framesDone), "frame_count", FrameCount, framesDone);
            if (remaining > 0) begin
                have = nextData < pushed.size();
                expB = have ? pushed[nextData] : 8'h00;
                check(have && TxData == expB && AdcReadEnable && !GenDataAck && prevReady, "data_byte",
                      {AdcReadEnable, GenDataAck, prevReady, TxData}, {3'b101, expB});
                nextData++;
                csumAcc = csumAcc + expB;
                remaining--;
                if (remaining == 0) begin
                    if (CsBytes != 0) csumPending = 1'b1;
                    else framesDone++;
                end
            end else if (csumPending) begin
                check(TxData == csumAcc && !AdcReadEnable && !GenDataAck, "checksum_byte",
                      {AdcReadEnable, GenDataAck, TxData}, {2'b00, csumAcc});
                csumPending = 1'b0;
                framesDone++;
            end else if (gen2) begin
                have = genQ.size() > 0;
                expB = have ? genQ[0] : 8'h00;
                check(have && TxData == expB && GenDataAck && !AdcReadEnable, "gen_byte",
                      {AdcReadEnable, GenDataAck, TxData}, {2'b01, expB});
                if (have) void'(genQ.pop_front());
            end else begin
                check(TxData == 8'hA5 && !AdcReadEnable && !GenDataAck, "header_byte",
                      {AdcReadEnable, GenDataAck, TxData}, {2'b00, 8'hA5});
                remaining = BurstLen;
                csumAcc = 8'h00;
            end
            txLog.push_back(TxData);
            lastStart = cyc;
        end else begin
            check(!AdcReadEnable && !GenDataAck, "stray_pulse", {AdcReadEnable, GenDataAck}, 0);
        end
        if (AdcReadEnable) popCnt++;
        if (GenDataAck) begin
            ackCnt++;
            fcAtAck = int'(FrameCount);
        end
        prevBusy  = TxBusy;
        prevReady = AdcDataReady;
        gen2      = gen1;
        gen1      = GenDataWrite;
        rstPrev   = Reset;
        if (Reset) begin
            remaining   = 0;
            csumPending = 1'b0;
            framesDone  = 0;
            lastStart   = -100;
        end
    end

    task automatic refresh();
        AdcDataReady = (fifoQ.size() > 0) && !holdOff;
        AdcData      = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    endtask

    // One clock: FIFO pops, UART busy model and ack handshake react to the pulses just seen.
    task automatic cycle();
        bit sStart, sPop, sAck;
        @(negedge Clock);
        sStart = TxStart;
        sPop   = AdcReadEnable;
        sAck   = GenDataAck;
        @(posedge Clock);
        #1;
        if (sPop && fifoQ.size() > 0) void'(fifoQ.pop_front());
        if (Reset) busyLeft = 0;
        else if (sStart) busyLeft = busyLen;
        else if (busyLeft > 0) busyLeft--;
        TxBusy = busyLeft > 0;
        if (sAck) GenDataWrite = 1'b0;
        refresh();
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifoQ.push_back(b);
        pushed.push_back(b);
        refresh();
    endtask

    task automatic requestGen(input logic [7:0] b);
        GenData      = b;
        GenDataWrite = 1'b1;
        genQ.push_back(b);
    endtask

    task automatic waitQuiet(input int bound, input string name);
        int n = 0;
        while (!(fifoQ.size() == 0 && !GenDataWrite && remaining == 0 && !csumPending &&
                 (cyc - lastStart) > 15) && n < bound) begin
            cycle();
            n++;
        end
        check(n < bound, name, n, bound);
    endtask

    task automatic waitPops(input int target, input int bound, input string name);
        int n = 0;
        while (popCnt < target && n < bound) begin
            cycle();
            n++;
        end
        check(n < bound, name, popCnt, target);
    endtask

    task automatic checkLog(input string name);
        bit ok = txLog.size() == expQ.size();
        if (ok) begin
            for (int i = 0; i < expQ.size(); i++) ok &= (txLog[i] == expQ[i]);
        end
        check(ok, name, txLog.size(), expQ.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int starts0;
        int r;
        Reset        = 1'b1;
        GenData      = 8'h00;
        GenDataWrite = 1'b0;
        AdcData      = 8'h00;
        AdcDataReady = 1'b0;
        TxBusy       = 1'b0;
        repeat (3) cycle();
        Reset = 1'b0;
        cycle();

        // General byte with a slow UART
        busyLen = 10;
        txLog.delete();
        requestGen(8'h3C);
        waitQuiet(200, "gen_timeout");
        expQ = {8'h3C};
        checkLog("gen_stream");
        check(ackCnt == 1, "gen_ack_count", ackCnt, 1);
        check(popCnt == 0, "gen_no_pop", popCnt, 0);

        // Two back-to-back frames from a preloaded FIFO, fastest UART
        busyLen = 0;
        txLog.delete();
        for (int i = 0; i < 8; i++) pushByte(8'(i));
        waitQuiet(400, "frames_timeout");
        expQ = {8'hA5, 8'h00, 8'h01, 8'h02, 8'h03};
        if (CsBytes != 0) expQ.push_back(8'h06);
        expQ.push_back(8'hA5);
        for (int i = 4; i < 8; i++) expQ.push_back(8'(i));
        if (CsBytes != 0) expQ.push_back(8'h16);
        checkLog("two_frames_stream");
        check(FrameCount == 16'd2, "two_frames_count", FrameCount, 2);
        check(popCnt == 8, "two_frames_pops", popCnt, 8);

        // General request raised mid-frame waits for the frame to finish
        busyLen = 2;
        txLog.delete();
        base = popCnt;
        for (int i = 0; i < 4; i++) pushByte(8'h10 + 8'(i));
        waitPops(base + 2, 200, "midgen_pop_timeout");
        requestGen(8'h77);
        waitQuiet(300, "midgen_timeout");
        expQ = {8'hA5, 8'h10, 8'h11, 8'h12, 8'h13};
        if (CsBytes != 0) expQ.push_back(8'h46);
        expQ.push_back(8'h77);
        checkLog("midgen_stream");
        check(fcAtAck == 3, "midgen_ack_after_frame", fcAtAck, 3);

        // FIFO runs dry for 20 cycles mid-frame
        busyLen = 1;
        txLog.delete();
        base = popCnt;
        for (int i = 0; i < 4; i++) pushByte(8'h20 + 8'(i));
        waitPops(base + 2, 200, "gap_pop_timeout");
        holdOff = 1'b1;
        refresh();
        starts0 = startCnt;
        repeat (20) cycle();
        check(startCnt == starts0, "gap_no_start", startCnt - starts0, 0);
        holdOff = 1'b0;
        refresh();
        waitQuiet(300, "gap_timeout");
        expQ = {8'hA5, 8'h20, 8'h21, 8'h22, 8'h23};
        if (CsBytes != 0) expQ.push_back(8'h86);
        checkLog("gap_stream");

        // Reset while waiting after the second data byte
        busyLen = 3;
        base = popCnt;
        for (int i = 0; i < 4; i++) pushByte(8'h40 + 8'(i));
        waitPops(base + 2, 200, "rst_pop_timeout");
        txLog.delete();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        cycle();
        check(FrameCount == 16'd0, "rst_frame_count", FrameCount, 0);
        pushByte(8'h44);
        pushByte(8'h45);
        waitQuiet(300, "rst_timeout");
        expQ = {8'hA5, 8'h42, 8'h43, 8'h44, 8'h45};
        if (CsBytes != 0) expQ.push_back(8'h0E);
        checkLog("rst_stream");
        check(FrameCount == 16'd1, "rst_frame_done", FrameCount, 1);

        // Checksum wraps modulo 256
        busyLen = 0;
        txLog.delete();
        pushByte(8'hFF);
        pushByte(8'h02);
        pushByte(8'h10);
        pushByte(8'h01);
        waitQuiet(300, "csum_timeout");
        expQ = {8'hA5, 8'hFF, 8'h02, 8'h10, 8'h01};
        if (CsBytes != 0) expQ.push_back(8'h12);
        checkLog("csum_stream");

        // Random traffic against the model
        for (int it = 0; it < 60; it++) begin
            busyLen = $urandom_range(0, 6);
            r = $urandom_range(0, 3);
            if (r == 0 || r == 3) begin
                for (int k = 0; k < 4; k++) pushByte(8'($urandom));
            end
            if ((r == 1 || r == 3) && !GenDataWrite) requestGen(8'($urandom));
            if (r == 2) begin
                holdOff = 1'b1;
                refresh();
                repeat ($urandom_range(1, 8)) cycle();
                holdOff = 1'b0;
                refresh();
            end
            repeat ($urandom_range(0, 15)) cycle();
        end
        waitQuiet(5000, "random_timeout");
        check(FrameCount == 16'(framesDone), "random_frame_count", FrameCount, framesDone);
        check(genQ.size() == 0, "random_gen_drained", genQ.size(), 0);
        check(nextData == pushed.size(), "random_data_drained", nextData, pushed.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_tx_scheduler.md
# capture_tx_scheduler

Sequences readout of the ADC capture storage FIFO onto the shared UART transmitter and arbitrates that transmitter against general-purpose command/response bytes. ADC bytes go out as framed bursts: a header byte, then exactly BURST_LEN data bytes. General bytes are sent between frames. The block sits between the capture storage (read side) and the UART byte transmitter, in the read-clock domain.

## Interface
- BURST_LEN, 256: data bytes per ADC frame; legal range 1..65535.
- HEADER_BYTE, 8'hA5: first byte of every ADC frame.
- Clock  in  1  single clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- GenData  in  8  general byte; held stable by the requester while GenDataWrite=1.
- GenDataWrite  in  1  level request to send GenData.
- GenDataAck  out  1  one-cycle pulse; GenData has been accepted.
- AdcData  in  8  storage FIFO head byte (first-word-fall-through).
- AdcDataReady  in  1  storage FIFO not empty.
- AdcReadEnable  out  1  one-cycle pop pulse to the storage FIFO.
- TxData  out  8  byte to the UART transmitter.
- TxStart  out  1  one-cycle start pulse to the UART.
- TxBusy  in  1  UART is shifting a byte.
- FrameCount  out  16  completed ADC frames since reset; wraps 65535->0.

## Operation
- States: IDLE, GEN, HDR, DATA, CSUM (macro only), WAIT. Every byte is sent by entering WAIT with a return state.
- IDLE priority: GenDataWrite=1 -> GEN. Otherwise, AdcDataReady=1 -> HDR. Otherwise stay in IDLE.
- GEN: drive TxData=GenData, TxStart=1, GenDataAck=1 for one cycle, then go to WAIT and return to IDLE.
- HDR: drive TxData=HEADER_BYTE, TxStart=1, clear the byte counter, then WAIT -> DATA.
- DATA: if AdcDataReady=1, drive TxData=AdcData, TxStart=1 and AdcReadEnable=1 in the same cycle, increment the byte counter, then WAIT.
  - WAIT returns to DATA while counter < BURST_LEN.
  - At counter = BURST_LEN, WAIT returns to CSUM if the macro is defined, else to IDLE, and FrameCount increments.
  - If AdcDataReady=0, stay in DATA with no pulses until it rises.
- A frame is never interrupted. General requests arriving mid-frame wait until the frame completes and the block is back in IDLE.
- WAIT:
  - Ignore TxBusy in the first cycle after TxStart (guard cycle).
  - From the second cycle on, leave WAIT when TxBusy=0.
- Byte counter is 16 bits and compares against BURST_LEN. No wrap is possible within a frame.

## Timing
- Reset values: GenDataAck=0, AdcReadEnable=0, TxStart=0, TxData=8'h00, FrameCount=0, state=IDLE, counter=0, checksum=0.
- All outputs are registered.
- GenDataWrite sampled high in IDLE at edge N: TxStart, GenDataAck and TxData=GenData are valid after edge N+1.
- Minimum spacing between two TxStart pulses is 3 cycles: start, guard, then TxBusy low observed.
- GenDataWrite and AdcDataReady both high in IDLE: GEN wins. The frame starts on the next IDLE visit.
- Reset mid-frame:
  - Immediate return to IDLE; all outputs go to reset values on the next edge.
  - No pop is issued in the reset cycle.
  - Bytes left in the FIFO start a new frame with a fresh header.
- TxBusy stuck high: the block waits in WAIT indefinitely, with no timeout.

## Configuration
- CAPTURE_CHECKSUM_EN defined:
  - An 8-bit checksum accumulates the modulo-256 sum of the frame's data bytes. The header is excluded.
  - CSUM sends the checksum as one extra byte, then WAIT -> IDLE.
  - The checksum clears in HDR.
  - FrameCount increments after the checksum byte is sent.
- CAPTURE_CHECKSUM_EN undefined: no CSUM state and no accumulator. A frame is HEADER_BYTE plus BURST_LEN bytes.

## Structure
- Package capture_pkg:
  - state enum
  - default HEADER_BYTE
  - checksum width
  - FrameCount width
- Sub-module tx_byte_handshake:
  - Owns the TxStart pulse, guard cycle and TxBusy wait.
  - Interface: load/byte in, done out.
- The scheduler FSM, counter and checksum stay in the top module.

## Test plan
- Reset, then GenDataWrite=1 with GenData=8'h3C and UART busy for 10 cycles per byte -> one TxStart with TxData=8'h3C, one GenDataAck, no AdcReadEnable.
- BURST_LEN=4, FIFO preloaded with 8'h00..8'h07 -> TxData sequence A5,00,01,02,03, then A5,04..07; FrameCount=2; exactly 8 AdcReadEnable pulses.
- GenDataWrite raised during the second data byte of a frame -> the frame completes uninterrupted, then the general byte is sent; GenDataAck occurs after FrameCount increments.
- AdcDataReady dropped for 20 cycles mid-frame -> no TxStart or pop during the gap; the frame resumes with the correct next byte.
- Reset asserted in WAIT after data byte 2 -> all outputs 0 next cycle; the next transmitted byte is A5.
- CAPTURE_CHECKSUM_EN, BURST_LEN=4, data 8'hFF,8'h02,8'h10,8'h01 -> checksum byte 8'h12 follows the data.
